// File: rtl/spongent_pi_index.sv
// Spongent pLayer index generator: maps bit position j to (j*B/4) mod (B-1), B-1 -> B-1, j >= B -> all-ones.
// Define PI_COMB_OUT_EN for a purely combinational, zero-latency output (clk/rst unused); default is registered.
module spongent_pi_index #(
  parameter int B     = 384,
  parameter int OUT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in,
  output logic [OUT_W-1:0] out
);

  localparam int D     = B - 1;
  localparam int MULT  = B / 4;
  localparam int PW    = 18;
  localparam int SH    = 18;
  localparam int QW    = PW + SH;
  // Floor reciprocal: quotient estimate is low by at most one for any product below 2**17.
  localparam int RECIP = (1 << SH) / D;

  logic [PW-1:0]    w_prod;
  logic [QW-1:0]    w_qmul;
  logic [PW-1:0]    w_q;
  logic [PW-1:0]    w_qd;
  logic [PW-1:0]    w_r0;
  logic [PW-1:0]    w_r;
  logic             w_in_perm;
  logic             w_in_fix;
  logic [OUT_W-1:0] w_f;

  assign w_prod    = PW'(in[8:0]) * PW'(MULT);
  assign w_qmul    = QW'(w_prod) * QW'(RECIP);
  assign w_q       = PW'(w_qmul >> SH);
  assign w_qd      = w_q * PW'(D);
  assign w_r0      = w_prod - w_qd;
  assign w_r       = (w_r0 >= PW'(D)) ? (w_r0 - PW'(D)) : w_r0;

  // Range decisions look at all 32 input bits.
  assign w_in_perm = (in < 32'(D));
  assign w_in_fix  = (in == 32'(D));

  always_comb begin
    w_f = {OUT_W{1'b1}};
    if (w_in_perm) begin
      w_f = OUT_W'(w_r);
    end else if (w_in_fix) begin
      w_f = OUT_W'(D);
    end
  end

`ifdef PI_COMB_OUT_EN
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;
  assign out = w_f;
`else
  logic [OUT_W-1:0] r_out;

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_f;
    end
  end

  assign out = r_out;
`endif

endmodule

// File: tb/tb_spongent_pi_index.sv
// Directed bench for spongent_pi_index (B=384): literal vectors plus an arithmetic reference model checked every cycle.
module tb_spongent_pi_index;

  logic        clk;
  logic        rst;
  logic [31:0] in;
  logic [8:0]  out;

  int tests;
  int fails;
  bit chk_en;
  logic [8:0] m_exp;

  spongent_pi_index #(.B(384), .OUT_W(9)) dut (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] f_model(input logic [31:0] j);
    if (j < 32'd383) return 9'((j * 32'd96) % 32'd383);
    else if (j == 32'd383) return 9'd383;
    else return 9'h1FF;
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", nm, act, exp);
    end
  endtask

  // Reference model of what out must hold.
`ifdef PI_COMB_OUT_EN
  always_comb m_exp = f_model(in);
`else
  always @(posedge clk or negedge rst) begin
    if (!rst) m_exp <= 9'd0;
    else      m_exp <= f_model(in);
  end
`endif

  always @(negedge clk) begin
    if (chk_en) check("model", out, m_exp);
  end

  task automatic vec(input logic [31:0] v, input logic [8:0] e, input string nm);
    @(negedge clk);
    in = v;
`ifdef PI_COMB_OUT_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
    check(nm, out, e);
  endtask

  logic [31:0] vin [14];
  logic [8:0]  vexp[14];
  int seen [384];
  int bad_idx;
  int n_oor;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    in     = 32'd5;

`ifndef PI_COMB_OUT_EN
    // Reset held across an edge
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", out, 9'h000);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_in5", out, 9'h061);
    // Assert reset between edges: out must clear without a clock edge
    #2 rst = 1'b0;
    #1 check("async_reset", out, 9'h000);
    @(negedge clk);
    check("reset_hold1", out, 9'h000);
    @(negedge clk);
    check("reset_hold2", out, 9'h000);
    in  = 32'd9;
    rst = 1'b1;
    @(negedge clk);
    check("release_in9", out, 9'h062);
`else
    rst = 1'b1;
    chk_en = 1'b1;
    #1 check("comb_in5", out, 9'h061);
`endif

    vin[0]  = 32'd0;          vexp[0]  = 9'h000;
    vin[1]  = 32'd1;          vexp[1]  = 9'h060;
    vin[2]  = 32'd2;          vexp[2]  = 9'h0C0;
    vin[3]  = 32'd3;          vexp[3]  = 9'h120;
    vin[4]  = 32'd4;          vexp[4]  = 9'h001;
    vin[5]  = 32'd7;          vexp[5]  = 9'h121;
    vin[6]  = 32'hFE;         vexp[6]  = 9'h0FF;
    vin[7]  = 32'hFD;         vexp[7]  = 9'h09F;
    vin[8]  = 32'h100;        vexp[8]  = 9'h040;
    vin[9]  = 32'd382;        vexp[9]  = 9'h11F;
    vin[10] = 32'd383;        vexp[10] = 9'h17F;
    vin[11] = 32'd384;        vexp[11] = 9'h1FF;
    vin[12] = 32'h0001_0005;  vexp[12] = 9'h1FF;
    vin[13] = 32'hFFFF_FFFF;  vexp[13] = 9'h1FF;
    for (int i = 0; i < 14; i++) begin
      vec(vin[i], vexp[i], $sformatf("vec_0x%0h", vin[i]));
    end

    // Sweep 0..9 back to back
    for (int i = 0; i < 10; i++) begin
      vec(32'(i), f_model(32'(i)), $sformatf("sweep_%0d", i));
    end

    // Full sweep, one index per cycle, collecting outputs
    for (int i = 0; i < 384; i++) seen[i] = 0;
    n_oor = 0;
    for (int i = 0; i < 384; i++) begin
      @(negedge clk);
      in = 32'(i);
`ifdef PI_COMB_OUT_EN
      #1;
`else
      @(posedge clk);
      #1;
`endif
      if (out >= 9'd384) n_oor++;
      else seen[out] = seen[out] + 1;
    end
    bad_idx = 0;
    for (int i = 0; i < 384; i++) if (seen[i] != 1) bad_idx++;
    check("bijection_bad_count", 9'(bad_idx), 9'd0);
    check("bijection_oor_count", 9'(n_oor), 9'd0);

    // Random inputs checked by the model only
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in = (i % 2 == 0) ? 32'($urandom_range(0, 600)) : $urandom;
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
